// File: rtl/fifo_drain.sv
// Drains a registered-read FIFO into a valid/ready packet stream; 2 cycles rd_en->m_valid, 1 beat/cycle, 2-entry skid absorbs m_ready stalls.
// Optional FIFO_DRAIN_PARITY_EN adds m_parity (XOR of each entry, stored beside it).
module fifo_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic                  m_parity
`endif
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    logic                  pending;
    logic [1:0]            occ;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [CW-1:0]         beat;
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  pop;
    logic [2:0]            committed;
    logic [2:0]            room_limit;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    // Entries buffered plus the one in flight must stay below 2 after this cycle's pop.
    assign committed  = {1'b0, occ} + {2'b00, pending};
    assign room_limit = 3'd2 + {2'b00, pop};
    assign fifo_rd_en = rst_n & drain_en & ~fifo_empty & (committed < room_limit);

    assign m_data = m_valid ? mem[rd_ptr] : '0;
    assign m_last = m_valid & (beat == LAST_BEAT);
    assign busy   = pending | m_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            occ     <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            beat    <= '0;
        end else begin
            pending <= fifo_rd_en;
            occ     <= occ + {1'b0, pending} - {1'b0, pop};
            if (pending) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                beat   <= (beat == LAST_BEAT) ? '0 : beat + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pending) begin
            mem[wr_ptr] <= fifo_data;
        end
    end

`ifdef FIFO_DRAIN_PARITY_EN
    logic par [2];

    always_ff @(posedge clk) begin
        if (pending) begin
            par[wr_ptr] <= ^fifo_data;
        end
    end

    assign m_parity = m_valid ? par[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: upstream FIFO model plus a word-order/timing reference model.
module tb_fifo_drain;

    localparam int DW = 16;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          drain_en = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
`ifdef FIFO_DRAIN_PARITY_EN
    logic          m_parity;
`endif

    fifo_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
`ifdef FIFO_DRAIN_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO: words in up_mem[rd_idx..wr_idx-1], registered read data.
    logic [DW-1:0] up_mem [0:2047];
    int            wr_idx = 0;
    int            rd_idx = 0;
    int            edge_cnt = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= up_mem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    // Reference state: accept edge of each outstanding word, next expected word, beat position.
    int            acc_edge [$];
    logic [DW-1:0] stage_q [$];
    int            pop_idx = 0;
    int            beat = 0;
    int            rd_cnt = 0;
    int            nchk = 0;
    int            nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic de, input logic rdy);
        int   outst;
        logic ev, ep, er;
        @(negedge clk);
        drain_en = de;
        m_ready  = rdy;
        while (stage_q.size() > 0) begin
            up_mem[wr_idx] = stage_q.pop_front();
            wr_idx++;
        end
        #1;
        outst = acc_edge.size();
        // A word read at edge E is captured at E+1 and visible after it.
        ev = (outst > 0) && (edge_cnt >= acc_edge[0] + 1);
        ep = ev & m_ready;
        er = drain_en & (wr_idx != rd_idx) & ((outst - int'(ep)) < 2);
        chk("rd_en", fifo_rd_en, er);
        chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
        chk("m_valid", m_valid, ev);
        chk("busy", busy, outst != 0);
        chk("m_last", m_last, ev && (beat == PL - 1));
        if (ev) begin
            chk("m_data", m_data, up_mem[pop_idx]);
`ifdef FIFO_DRAIN_PARITY_EN
            chk("m_parity", m_parity, ^up_mem[pop_idx]);
`endif
        end
        if (ep) begin
            void'(acc_edge.pop_front());
            pop_idx++;
            beat = (beat == PL - 1) ? 0 : beat + 1;
        end
        if (er) begin
            acc_edge.push_back(edge_cnt + 1);
            rd_cnt++;
        end
    endtask

    task automatic do_reset(input logic de);
        @(negedge clk);
        rst_n    = 1'b0;
        drain_en = de;
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data", m_data, 0);
`ifdef FIFO_DRAIN_PARITY_EN
        chk("rst_m_parity", m_parity, 0);
`endif
        repeat (2) @(negedge clk);
        drain_en = 1'b0;
        m_ready  = 1'b0;
        rst_n    = 1'b1;
        acc_edge.delete();
        beat    = 0;
        pop_idx = rd_idx;
    endtask

    initial begin
        int r0;
        int p0;
        int guard;

        do_reset(1'b1);

        // Preloaded 1..8 at full rate; packet ends on 4 and 8.
        for (int v = 1; v <= 8; v++) stage_q.push_back(16'(v));
        repeat (14) step(1'b1, 1'b1);

        // Stalled sink: only two reads may be issued, head word held.
        r0 = rd_cnt;
        stage_q.push_back(16'h0011);
        stage_q.push_back(16'h0022);
        stage_q.push_back(16'h0033);
        repeat (10) step(1'b1, 1'b0);
        chk("stall_reads", rd_cnt - r0, 2);
        repeat (6) step(1'b1, 1'b1);

        // Sink toggling every cycle.
        for (int v = 0; v < 6; v++) stage_q.push_back(16'h0100 + 16'(v));
        for (int i = 0; i < 16; i++) step(1'b1, (i % 2) == 0);
        repeat (4) step(1'b1, 1'b1);

        // drain_en drops right after the first accepted read.
        for (int v = 0; v < 3; v++) stage_q.push_back(16'h0200 + 16'(v));
        r0 = rd_cnt;
        guard = 0;
        while (rd_cnt == r0 && guard < 20) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("drain_read_seen", rd_cnt - r0, 1);
        r0 = rd_cnt;
        repeat (8) step(1'b0, 1'b1);
        chk("no_read_after_off", rd_cnt - r0, 0);
        chk("busy_idle", busy, 0);
        repeat (8) step(1'b1, 1'b1);

        // Reset mid-packet with two entries buffered.
        for (int v = 0; v < 8; v++) stage_q.push_back(16'h0300 + 16'(v));
        p0 = pop_idx;
        guard = 0;
        while (pop_idx - p0 < 2 && guard < 20) begin
            step(1'b1, 1'b1);
            guard++;
        end
        repeat (4) step(1'b1, 1'b0);
        chk("pre_reset_buffered", {31'b0, m_valid}, 1);
        do_reset(1'b1);
        p0 = pop_idx;
        repeat (10) step(1'b1, 1'b1);
        chk("post_reset_beats", pop_idx - p0, 4);

        // Random traffic.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) stage_q.push_back(16'($urandom));
            step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
        end

        guard = 0;
        while ((pop_idx != wr_idx || acc_edge.size() != 0) && guard < 300) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("drain_done", pop_idx, wr_idx);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of FIFO read data and stream data.
REQ-002 SHALL have parameter PKT_LEN, default 4, stream beats per packet (legal range 1..256).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port drain_en  input  1  permits issuing new FIFO reads when high.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid one cycle after an accepted read.
REQ-008 SHALL have port fifo_rd_en  output  1  read request to upstream FIFO.
REQ-009 SHALL have port m_valid  output  1  stream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts beat.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-012 SHALL have port m_last  output  1  marks final beat of a packet.
REQ-013 SHALL have port busy  output  1  high while any read is in flight or any entry is buffered.

Function
REQ-014 SHALL treat a read as accepted in a cycle where fifo_rd_en=1 and fifo_empty=0; SHALL set a registered pending flag for that read.
REQ-015 SHALL capture fifo_data into a 2-entry in-order buffer on the cycle after an accepted read (pending=1), never dropping it.
REQ-016 SHALL drive fifo_rd_en = drain_en & !fifo_empty & (occupancy + pending - pop < 2), where pop = m_valid & m_ready, so no capture ever overflows the buffer.
REQ-017 SHALL sustain one beat per cycle when FIFO is non-empty and m_ready is held high, after a 2-cycle initial latency from fifo_rd_en to m_valid.
REQ-018 SHALL drive m_valid = (occupancy != 0) and m_data = oldest buffered entry; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-019 SHALL handle simultaneous capture and pop in one cycle with occupancy unchanged and order preserved.
REQ-020 SHALL keep a beat counter 0..PKT_LEN-1, incremented on each pop, wrapping to 0 after PKT_LEN-1.
REQ-021 SHALL drive m_last = m_valid & (beat counter == PKT_LEN-1); PKT_LEN=1 SHALL assert m_last on every beat.
REQ-022 SHALL, when drain_en falls, stop issuing reads next cycle, still capture any pending read, and continue delivering buffered beats.
REQ-023 SHALL drive busy = pending | (occupancy != 0).
REQ-024 SHALL never assert fifo_rd_en while fifo_empty=1.

Reset
REQ-025 SHALL on rst_n low asynchronously clear pending, occupancy, buffer pointers and beat counter.
REQ-026 SHALL hold fifo_rd_en=0, m_valid=0, m_last=0, busy=0, m_data=0 during reset; reset mid-packet SHALL discard buffered and in-flight data and restart at beat 0.

Configuration
REQ-027 SHALL, with macro FIFO_DRAIN_PARITY_EN defined, add output m_parity (1 bit) equal to XOR-reduction of the entry captured, stored alongside that entry and presented with m_data, reset 0.
REQ-028 SHALL, without FIFO_DRAIN_PARITY_EN, omit m_parity port and parity storage entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover: FIFO preloaded 8 words 0x0001..0x0008, drain_en=1, m_ready=1 -> 8 beats on consecutive cycles in order, m_last on 0x0004 and 0x0008, fifo_rd_en never high while fifo_empty=1.
REQ-030 SHALL cover: 3 words queued, m_ready=0 for 10 cycles -> exactly 2 reads issued, m_valid=1 with m_data stable at first word; on m_ready=1 all 3 delivered in order.
REQ-031 SHALL cover: m_ready toggling 1/0 every cycle with 6 words -> no loss, no duplication, buffer occupancy never exceeds 2.
REQ-032 SHALL cover: drain_en deasserted right after a read accepted -> that word still delivered, no further fifo_rd_en, busy falls after final pop.
REQ-033 SHALL cover: rst_n pulsed low after beat 2 of a packet with 2 entries buffered -> all outputs 0 immediately, subsequent beats restart at counter 0 (m_last on 4th post-reset beat).
REQ-034 SHALL cover, with FIFO_DRAIN_PARITY_EN: data 0x0007 -> m_parity=1; 0x0003 -> m_parity=0.
